// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BE_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte-enable patterns that describe a naturally aligned byte, halfword or word.
  function automatic logic be_legal(input logic [BE_W-1:0] be);
    logic ok;
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous byte-enabled write, asynchronous read
// from the same word index. Contents are intentionally not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  input  logic [BE_W-1:0]                be,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane write; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target for the pipeline memory stage: valid/ready request in,
// valid/ready response out, programmable wait states between accept and response.
// Optional feature macro: DMEM_ALIGN_CHECK_EN adds misaligned-address and
// illegal-byte-enable errors on top of the always-on range error.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W      = 4;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(WORD_BYTES * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES == 0) ? CNT_W'(0) : CNT_W'(WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_write_q, req_write_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              cur_write;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              acc_err;
  logic              commit;
  logic              mem_we_c;
  logic [IDX_W-1:0]  mem_idx;
  logic [31:0]       mem_rdata;

  // Access being committed: live inputs when going IDLE->RESP directly, else the captured request.
  always_comb begin
    cur_write = req_write_q;
    cur_addr  = req_addr_q;
    cur_wdata = req_wdata_q;
    cur_be    = req_be_q;
    if (state_q == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
  end

  // Error classification for the access being committed.
  always_comb begin
    acc_err = ({1'b0, cur_addr} >= ADDR_LIMIT);
`ifdef DMEM_ALIGN_CHECK_EN
    if (cur_addr[1:0] != 2'b00) begin
      acc_err = 1'b1;
    end
    if (cur_write && !be_legal(cur_be)) begin
      acc_err = 1'b1;
    end
`endif
  end

`ifndef DMEM_ALIGN_CHECK_EN
  // Byte offset within the word plays no role without the alignment check.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cur_addr[1:0];
`endif

  assign mem_idx = cur_addr[2 +: IDX_W];

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_c),
    .idx   (mem_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (mem_rdata)
  );

  // Next-state, wait counter, request capture and response generation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_be_d    = req_be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    commit      = 1'b0;
    mem_we_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_write_d = req_write;
          req_addr_d  = req_addr;
          req_wdata_d = req_wdata;
          req_be_d    = req_be;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Commit happens on the edge that enters RESP; errored accesses never write.
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (cur_write || acc_err) ? 32'd0 : mem_rdata;
      mem_we_c    = cur_write && !acc_err;
    end

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; storage itself lives in dmem_array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_be_q    <= req_be_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver computes expected
// responses from a word-array model and queues them; a monitor pops and
// compares on every response handshake and checks hold stability.
module tb_data_mem_responder;

  localparam int unsigned WS    = 1;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  data_mem_responder #(
    .ADDR_W      (32),
    .DEPTH_WORDS (DEPTH),
    .WAIT_STATES (WS)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [DEPTH];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          force_lo = 1'b0;
  bit          force_hi = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request; when tracked, update the model, queue the expected
  // response and check accept-to-valid latency.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit track);
    exp_t e;
    logic err;
    int   idx;
    int   k;
    err = (a >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) err = 1'b1;
    if (w && !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
      err = 1'b1;
`endif
    idx = int'((a >> 2) % DEPTH);
    @(negedge clk);
    k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      chk("req_ready_timeout", 32'(k), 32'd0);
      return;
    end
    if (track) begin
      e.err   = err;
      e.rdata = (w || err) ? 32'd0 : mdl[idx];
      if (w && !err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        end
      end
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (track) begin
      k = 0;
      while (rsp_valid !== 1'b1 && k < 50) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("latency", 32'(k), 32'(WS));
    end
  endtask

  // Monitor: drives rsp_ready, compares every handshake against the queue,
  // and checks that a stalled response holds its payload.
  initial begin
    bit          hold;
    logic [31:0] hd;
    logic        he;
    exp_t        e;
    hold = 1'b0;
    hd   = 32'd0;
    he   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold      = 1'b0;
        rsp_ready = 1'b0;
        exp_q.delete();
      end else begin
        if (hold) begin
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_rdata", rsp_rdata, hd);
          chk("hold_err", 32'(rsp_err), 32'(he));
        end
        hold = 1'b0;
        rsp_ready = force_hi ? 1'b1 : (force_lo ? 1'b0 : ($urandom_range(0, 3) != 0));
        if (rsp_valid === 1'b1) begin
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
          end else begin
            hold = 1'b1;
            hd   = rsp_rdata;
            he   = rsp_err;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int          k;
    logic        w;
    logic [31:0] a;
    int          r;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-word store then load back, then preload the remaining words.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i != 4) issue(1'b1, 32'(i * 4), $urandom, 4'b1111, 1'b1);
    end

    // Single-byte store merges into the existing word.
    issue(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1'b1);
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);

    // Out-of-range load and store; word 0 (same index bits) must be untouched.
    issue(1'b0, 32'h400, 32'h0, 4'b0000, 1'b1);
    issue(1'b1, 32'h400, 32'h5A5A5A5A, 4'b1111, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 4'b0000, 1'b1);

    // No-op store with all byte enables low.
    issue(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, 1'b1);
    issue(1'b0, 32'h14, 32'h0, 4'b0000, 1'b1);

    // Response held off for five cycles.
    issue(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);
    force_lo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_busy", 32'(busy), 32'd1);
    end
    force_lo = 1'b0;
    force_hi = 1'b1;
    @(posedge clk);
    #1;
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    force_hi = 1'b0;

    // Reset while a store waits: the store must be dropped.
    issue(1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 4'b0000, 1'b1);

    // Misaligned load and odd byte-enable store.
    issue(1'b0, 32'h12, 32'h0, 4'b0000, 1'b1);
    issue(1'b1, 32'h30, 32'hCAFEF00D, 4'b0101, 1'b1);
    issue(1'b0, 32'h30, 32'h0, 4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'h400 + ($urandom & 32'h0FFF_FFFF);
      else if (r == 1) a = 32'($urandom_range(0, 1023));
      else             a = 32'($urandom_range(0, 255)) * 32'd4;
      issue(w, a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
    end

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
